prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS checker that consumes the bit stream produced by the team's Fibonacci LFSR generator, one bit per valid cycle.
- Self-synchronises by loading its local LFSR from received bits, then free-runs and compares.
- Declares lock and counts bit errors.
- Drops lock when the error density in a window exceeds a threshold.
- Sits directly downstream of the generator, or after a link/loopback, in BIST and link-test paths.

Parameters:
- LENGTH, 16, LFSR length. Local state is indexed [0:LENGTH-1]; new bit enters index 0.
- TAPS, 16'b0110100000000001, tap mask [0:LENGTH-1]. Predicted bit = XOR-reduce(TAPS & state). Must match the generator.
- LOCK_CNT, 32, consecutive matches required to declare lock (≥1).
- WIN, 256, error-density window length in valid bits (≥2).
- ERR_THRESH, 8, errors within one window that force loss of lock (1..WIN).
- CNT_W, 16, error counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_bit is valid this cycle.
- rx_bit  input  1  received PRBS bit, i.e. the generator's feedback bit.
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  registered; checker in LOCKED state.
- err_pulse  output  1  registered; one-cycle pulse per mismatching bit while LOCKED.
- err_cnt  output  CNT_W  registered; saturating error count.

Behaviour:
- Reset (async, rst=1):
  - State → SEARCH; state register = all zeros; fill_cnt, match_cnt, win_bits, win_err = 0.
  - locked=0, err_pulse=0, err_cnt=0.
  - Reset mid-lock behaves identically.
- rx_valid=0: all registers hold; err_pulse=0 next cycle.
- pred = ^(TAPS & state), computed combinationally from the current state.
- SEARCH, on each valid bit:
  - state ← {rx_bit, state[0:LENGTH-2]}.
  - If fill_cnt < LENGTH: fill_cnt++, no comparison.
  - Else compare: if pred==rx_bit and state≠0 then match_cnt++, else match_cnt←0.
  - When a match brings match_cnt to LOCK_CNT: go to LOCKED; locked=1 from the next edge.
  - Clear win_bits and win_err on entry to LOCKED.
  - No errors are counted in SEARCH; err_pulse stays 0.
- LOCKED, on each valid bit:
  - state ← {pred, state[0:LENGTH-2]} (free-run; received bit not loaded).
  - Mismatch (rx_bit≠pred): err_pulse=1 next cycle; err_cnt++ saturating at 2^CNT_W-1; win_err++.
  - win_bits++. When win_bits reaches WIN, set win_bits←0 and win_err←0 on that bit, after the threshold check.
  - If an error brings win_err to ERR_THRESH: next state SEARCH; locked=0 next edge; state, fill_cnt and match_cnt cleared.
- clr_cnt:
  - err_cnt←0 on the next edge.
  - If an error occurs the same cycle, clear wins (err_cnt=0) but err_pulse still fires.
  - clr_cnt does not affect lock or the window counters.
- Latency: err_pulse is one cycle after the erroneous bit; locked rises one cycle after the LOCK_CNT-th match.
- All-zero input never locks (state≠0 guard).

Optional Feature:
- Macro: PRBS_CHK_BITCNT_EN.
- Defined:
  - Adds output bit_cnt [31:0]: count of valid bits checked while LOCKED.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst and clr_cnt; holds in SEARCH.
  - Bit-error ratio = err_cnt/bit_cnt.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Generator seeded 16'hACE1 feeds rx_bit with rx_valid=1 continuously → locked=1 at the edge after the 48th valid bit (16 fill + 32 matches); err_pulse never asserts; err_cnt=0.
- After lock, invert one bit → err_pulse high exactly one cycle later for one cycle; err_cnt=1; locked stays 1.
- After lock, invert 8 bits within 100 bits → locked=0 after the 8th error, err_cnt=8. Uninterrupted stream then relocks 48 valid bits later.
- After lock, 7 errors in window 1 and 1 error in window 2 → lock retained, err_cnt=8.
- Constant 0 stream for 1000 bits → locked stays 0. rx_valid toggled 50% on a good stream → lock after 48 valid bits regardless of gaps.
- clr_cnt asserted on the same cycle as an error with err_cnt=5 → err_cnt=0, err_pulse=1. rst pulsed while locked → locked, err_cnt, err_pulse all 0 immediately (async).

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker
//   Serial PRBS checker for the Fibonacci LFSR generator stream. It loads
//   its local LFSR from received bits until it has seen LOCK_CNT consecutive
//   correct predictions, then free-runs and flags every mismatching bit.
//   Lock is dropped when ERR_THRESH errors land inside one WIN-bit window.
//
// Optional feature (macro PRBS_CHK_BITCNT_EN):
//   Adds the bit_cnt output, a saturating count of valid bits checked while
//   locked, so that the bit-error ratio is err_cnt / bit_cnt.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   rx_valid   in   rx_bit is valid this cycle
//   rx_bit     in   received PRBS bit (the generator's feedback bit)
//   clr_cnt    in   synchronous clear of err_cnt (and bit_cnt when present)
//   locked     out  registered, high while in the locked state
//   err_pulse  out  registered, one-cycle pulse per mismatching bit when locked
//   err_cnt    out  registered, saturating error count [CNT_W-1:0]
//   bit_cnt    out  registered, saturating checked-bit count [31:0] (optional)

module prbs_checker #(
  parameter int                LENGTH     = 16,
  parameter logic [0:LENGTH-1] TAPS       = 16'b0110100000000001,
  parameter int                LOCK_CNT   = 32,
  parameter int                WIN        = 256,
  parameter int                ERR_THRESH = 8,
  parameter int                CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic             rx_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [31:0]      bit_cnt,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(LENGTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBITS_W = $clog2(WIN);
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_DONE   = FILL_W'(LENGTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WBITS_W-1:0] WIN_LAST    = WBITS_W'(WIN - 1);
  localparam logic [WERR_W-1:0]  THRESH_LAST = WERR_W'(ERR_THRESH - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_n;
  logic [0:LENGTH-1]   lfsr_q, lfsr_n;
  logic [FILL_W-1:0]   fill_q, fill_n;
  logic [MATCH_W-1:0]  match_q, match_n;
  logic [WBITS_W-1:0]  win_bits_q, win_bits_n;
  logic [WERR_W-1:0]   win_err_q, win_err_n;
  logic [CNT_W-1:0]    err_cnt_n;
  logic                err_pulse_n;
  logic                pred;
  logic                mismatch;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]         bit_cnt_n;
`endif

  // Next bit the local LFSR expects, straight from the current state.
  assign pred     = ^(TAPS & lfsr_q);
  assign mismatch = (rx_bit != pred);

  // Register stage: every piece of state, including the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      lfsr_q     <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      win_bits_q <= '0;
      win_err_q  <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      locked     <= 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt    <= '0;
`endif
    end else begin
      state_q    <= state_n;
      lfsr_q     <= lfsr_n;
      fill_q     <= fill_n;
      match_q    <= match_n;
      win_bits_q <= win_bits_n;
      win_err_q  <= win_err_n;
      err_cnt    <= err_cnt_n;
      err_pulse  <= err_pulse_n;
      locked     <= (state_n == ST_LOCKED);
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt    <= bit_cnt_n;
`endif
    end
  end

  // Next-state logic. Everything holds unless a valid bit arrives; clr_cnt
  // is applied last so it wins over an increment in the same cycle.
  always_comb begin
    state_n     = state_q;
    lfsr_n      = lfsr_q;
    fill_n      = fill_q;
    match_n     = match_q;
    win_bits_n  = win_bits_q;
    win_err_n   = win_err_q;
    err_cnt_n   = err_cnt;
    err_pulse_n = 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
    bit_cnt_n   = bit_cnt;
`endif

    if (rx_valid) begin
      case (state_q)
        ST_SEARCH: begin
          lfsr_n = {rx_bit, lfsr_q[0:LENGTH-2]};
          // Predictions are meaningless until the LFSR holds LENGTH real bits.
          if (fill_q < FILL_DONE) begin
            fill_n = fill_q + 1'b1;
          end else if (!mismatch && (lfsr_q != '0)) begin
            match_n = match_q + 1'b1;
            if (match_q == MATCH_LAST) begin
              state_n    = ST_LOCKED;
              win_bits_n = '0;
              win_err_n  = '0;
            end
          end else begin
            match_n = '0;
          end
        end

        ST_LOCKED: begin
          lfsr_n = {pred, lfsr_q[0:LENGTH-2]};
`ifdef PRBS_CHK_BITCNT_EN
          if (bit_cnt != '1) bit_cnt_n = bit_cnt + 1'b1;
`endif
          if (mismatch) begin
            err_pulse_n = 1'b1;
            if (err_cnt != '1) err_cnt_n = err_cnt + 1'b1;
          end
          // Threshold is checked before the window rollover so an error on
          // the last bit of a window can still break lock.
          if (mismatch && (win_err_q == THRESH_LAST)) begin
            state_n    = ST_SEARCH;
            lfsr_n     = '0;
            fill_n     = '0;
            match_n    = '0;
            win_bits_n = '0;
            win_err_n  = '0;
          end else if (win_bits_q == WIN_LAST) begin
            win_bits_n = '0;
            win_err_n  = '0;
          end else begin
            win_bits_n = win_bits_q + 1'b1;
            if (mismatch) win_err_n = win_err_q + 1'b1;
          end
        end

        default: state_n = ST_SEARCH;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_n = '0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_n = '0;
`endif
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
//   Self-checking bench for prbs_checker. A Fibonacci generator seeded with
//   16'hACE1 produces the stream; a queue-based reference model predicts
//   locked / err_pulse / err_cnt (and bit_cnt with PRBS_CHK_BITCNT_EN).
//   Each scenario task drives its own stimulus and checks inline.

module tb_prbs_checker;

  localparam int LENGTH     = 16;
  localparam int LOCK_CNT   = 32;
  localparam int WIN        = 256;
  localparam int ERR_THRESH = 8;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic             rx_bit;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [0:15] tap_mask = 16'b0110100000000001;
  logic [0:15] gen;

  // Reference model: recent local bits (index 0 = newest) plus counters.
  bit      m_hist[$];
  bit      m_lock;
  bit      m_pulse;
  int      m_fill, m_match, m_wbits, m_werr, m_errc;
  longint  m_bits;

  always #5 clk = ~clk;

  prbs_checker #(
    .LENGTH(LENGTH), .TAPS(16'b0110100000000001), .LOCK_CNT(LOCK_CNT),
    .WIN(WIN), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt(bit_cnt),
`endif
    .err_cnt(err_cnt)
  );

  // Generator: feedback bit is both the output and the new state[0].
  task automatic gen_bit(output logic b);
    b   = ^(tap_mask & gen);
    gen = {b, gen[0:14]};
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int i = 0; i < LENGTH; i++)
      if (tap_mask[i] && i < m_hist.size()) p ^= m_hist[i];
    return p;
  endfunction

  function automatic bit model_nonzero();
    foreach (m_hist[i]) if (m_hist[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_lock = 0; m_pulse = 0;
    m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0; m_errc = 0;
    m_bits = 0;
  endtask

  task automatic model_push(input bit x);
    m_hist.push_front(x);
    if (m_hist.size() > LENGTH) m_hist.delete(LENGTH);
  endtask

  task automatic model_step(input logic v, input logic b, input logic c);
    bit p, nz;
    m_pulse = 0;
    if (v) begin
      p  = model_pred();
      nz = model_nonzero();
      if (!m_lock) begin
        model_push(b);
        if (m_fill < LENGTH) m_fill++;
        else if (p == b && nz) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_lock = 1; m_wbits = 0; m_werr = 0;
          end
        end else m_match = 0;
      end else begin
        model_push(p);
        m_wbits++;
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (b != p) begin
          m_pulse = 1;
          if (m_errc < (1 << CNT_W) - 1) m_errc++;
          m_werr++;
        end
        if (b != p && m_werr == ERR_THRESH) begin
          m_lock = 0; m_hist.delete(); m_fill = 0; m_match = 0;
        end else if (m_wbits == WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end
    end
    if (c) begin
      m_errc = 0;
      m_bits = 0;
    end
  endtask

  // One clock: apply inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic c);
    rx_valid = v; rx_bit = b; clr_cnt = c;
    @(posedge clk); #1;
    model_step(v, b, c);
    cyc++;
  endtask

  task automatic send_good(input logic c);
    logic b;
    gen_bit(b);
    step(1'b1, b, c);
  endtask

  task automatic send_err(input logic c);
    logic b;
    gen_bit(b);
    step(1'b1, ~b, c);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    gen = 16'hACE1;
  endtask

  task automatic lock_up();
    repeat (LENGTH + LOCK_CNT) send_good(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked got=%b want=0", locked); end
    total++;
    if (err_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got=%b want=0", err_pulse); end
    total++;
    if (err_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", err_cnt); end
    do_reset();
  endtask

  task automatic test_lock_acquire();
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      send_good(1'b0);
      total++;
      if (locked !== (k == 48) || locked !== m_lock) begin
        bad++; $display("[TB] FAIL acq_lock bit=%0d got=%b want=%b", k, locked, (k == 48));
      end
    end
    for (int k = 0; k < 100; k++) begin
      send_good(1'b0);
      total++;
      if (locked !== 1'b1 || err_pulse !== 1'b0 || err_cnt !== '0) begin
        bad++; $display("[TB] FAIL acq_clean bit=%0d locked=%b pulse=%b cnt=%0d want 1/0/0", k, locked, err_pulse, err_cnt);
      end
    end
  endtask

  task automatic test_single_error();
    do_reset();
    lock_up();
    total++;
    if (locked !== 1'b1) begin bad++; $display("[TB] FAIL single_prelock got=%b want=1", locked); end
    send_err(1'b0);
    total++;
    if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL single_err pulse=%b cnt=%0d locked=%b want 1/1/1", err_pulse, err_cnt, locked);
    end
    send_good(1'b0);
    total++;
    if (err_pulse !== 1'b0 || err_cnt !== 16'd1) begin
      bad++; $display("[TB] FAIL single_after pulse=%b cnt=%0d want 0/1", err_pulse, err_cnt);
    end
  endtask

  task automatic test_lose_lock();
    int errs = 0;
    int next_pos;
    do_reset();
    lock_up();
    next_pos = $urandom_range(1, 12);
    for (int i = 1; i <= 100 && errs < ERR_THRESH; i++) begin
      if (i == next_pos) begin
        send_err(1'b0);
        errs++;
        next_pos = i + $urandom_range(1, 12);
      end else send_good(1'b0);
      total++;
      if (locked !== (errs < ERR_THRESH) || locked !== m_lock || err_cnt !== 16'(m_errc)) begin
        bad++; $display("[TB] FAIL lose_track bit=%0d errs=%0d locked=%b cnt=%0d want %b/%0d", i, errs, locked, err_cnt, m_lock, m_errc);
      end
    end
    total++;
    if (locked !== 1'b0 || err_cnt !== 16'd8 || err_pulse !== 1'b1) begin
      bad++; $display("[TB] FAIL lose_final locked=%b cnt=%0d pulse=%b want 0/8/1", locked, err_cnt, err_pulse);
    end
    for (int k = 1; k <= 48; k++) begin
      send_good(1'b0);
      total++;
      if (locked !== (k == 48)) begin
        bad++; $display("[TB] FAIL relock bit=%0d got=%b want=%b", k, locked, (k == 48));
      end
    end
  endtask

  task automatic test_window_split();
    do_reset();
    lock_up();
    for (int j = 1; j <= 300; j++) begin
      if (j == 5 || j == 40 || j == 80 || j == 120 || j == 160 || j == 200 || j == 256 || j == 257)
        send_err(1'b0);
      else
        send_good(1'b0);
      total++;
      if (locked !== 1'b1 || err_pulse !== m_pulse || err_cnt !== 16'(m_errc)) begin
        bad++; $display("[TB] FAIL window bit=%0d locked=%b pulse=%b exp %b cnt=%0d exp %0d", j, locked, err_pulse, m_pulse, err_cnt, m_errc);
      end
    end
    total++;
    if (err_cnt !== 16'd8) begin bad++; $display("[TB] FAIL window_cnt got=%0d want=8", err_cnt); end
  endtask

  task automatic test_zeros();
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (locked !== 1'b0 || err_pulse !== 1'b0) begin
        bad++; $display("[TB] FAIL zeros bit=%0d locked=%b pulse=%b want 0/0", k, locked, err_pulse);
      end
    end
  endtask

  task automatic test_gaps();
    int nv = 0;
    logic v, b;
    do_reset();
    for (int c = 0; c < 400 && nv < 60; c++) begin
      v = 1'(($urandom_range(0, 1)));
      if (v) begin gen_bit(b); nv++; end
      else b = 1'($urandom);
      step(v, b, 1'b0);
      total++;
      if (locked !== (nv >= 48) || locked !== m_lock) begin
        bad++; $display("[TB] FAIL gaps cyc=%0d valid=%0d locked=%b want=%b", c, nv, locked, (nv >= 48));
      end
    end
    total++;
    if (nv < 60) begin bad++; $display("[TB] FAIL gaps_budget valid=%0d want=60", nv); end
  endtask

  task automatic test_clr_same_cycle();
    do_reset();
    lock_up();
    repeat (5) begin
      send_err(1'b0);
      repeat (3) send_good(1'b0);
    end
    total++;
    if (err_cnt !== 16'd5) begin bad++; $display("[TB] FAIL clr_pre cnt=%0d want=5", err_cnt); end
    send_err(1'b1);
    total++;
    if (err_cnt !== '0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL clr_err cnt=%0d pulse=%b locked=%b want 0/1/1", err_cnt, err_pulse, locked);
    end
    send_good(1'b0);
    send_err(1'b0);
    total++;
    if (err_cnt !== 16'd1) begin bad++; $display("[TB] FAIL clr_recount cnt=%0d want=1", err_cnt); end
    send_good(1'b1);
    total++;
    if (err_cnt !== '0 || err_pulse !== 1'b0 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL clr_only cnt=%0d pulse=%b locked=%b want 0/0/1", err_cnt, err_pulse, locked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_up();
    repeat (3) send_good(1'b0);
    send_err(1'b0);
    total++;
    if (locked !== 1'b1 || err_pulse !== 1'b1 || err_cnt !== 16'd1) begin
      bad++; $display("[TB] FAIL arst_pre locked=%b pulse=%b cnt=%0d want 1/1/1", locked, err_pulse, err_cnt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== '0) begin
      bad++; $display("[TB] FAIL arst_now locked=%b pulse=%b cnt=%0d want 0/0/0", locked, err_pulse, err_cnt);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    gen = 16'hACE1;
  endtask

  task automatic test_random();
    int rates[6] = '{0, 2, 6, 1, 10, 0};
    logic v, b, e, c;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 500; k++) begin
        v = ($urandom_range(0, 3) != 0);
        e = ($urandom_range(0, 99) < rates[s]);
        c = ($urandom_range(0, 63) == 0);
        if (v) gen_bit(b);
        else b = 1'($urandom);
        step(v, b ^ e, c);
        total++;
        if (locked !== m_lock || err_pulse !== m_pulse || err_cnt !== 16'(m_errc)) begin
          bad++; $display("[TB] FAIL random seg=%0d cyc=%0d locked=%b exp %b pulse=%b exp %b cnt=%0d exp %0d", s, k, locked, m_lock, err_pulse, m_pulse, err_cnt, m_errc);
        end
`ifdef PRBS_CHK_BITCNT_EN
        total++;
        if (bit_cnt !== 32'(m_bits)) begin
          bad++; $display("[TB] FAIL random_bitcnt seg=%0d cyc=%0d got=%0d exp %0d", s, k, bit_cnt, m_bits);
        end
`endif
      end
    end
  endtask

  initial begin
    gen = 16'hACE1;
    model_reset();
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_lose_lock();
    test_window_split();
    test_zeros();
    test_gaps();
    test_clr_same_cycle();
    test_async_reset();
    test_random();
    rx_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
